// File: rtl/dlx_pkg.sv
// Shared DLX front-end definitions: fetch FSM states, the NOP encoding and
// the number of low address bits that must be zero for an aligned fetch.
package dlx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DLX_NOP     = 32'h0000_0000;
    localparam int          INSTR_ALIGN = 2;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch reader: issues one outstanding read per fetch over a
// req/ack memory port, holds the result for decode over valid/ready, and
// handles redirects (flush), misaligned PCs and memory timeouts.
module ifetch_unit
    import dlx_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_address,
    input  logic          fetch_en,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_addr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic          misaligned,
    output logic          bus_err
);

    // Counter only has to reach TIMEOUT-1, where it stops counting.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    fetch_state_t  state_reg, state_next;
    logic          mem_req_reg, mem_req_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] instr_reg, instr_next;
    logic [AW-1:0] instr_addr_reg, instr_addr_next;
    logic          instr_valid_reg, instr_valid_next;
    logic          misaligned_reg, misaligned_next;
    logic          bus_err_reg, bus_err_next;
    logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;

    logic          addr_misaligned;
    logic          timeout_hit;
    logic          launch;

    assign addr_misaligned = |i_address[INSTR_ALIGN-1:0];
    assign timeout_hit     = (tmo_cnt_reg == TMO_LAST);

    // State and every output are registered; reset drops mem_req at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            instr_reg       <= '0;
            instr_addr_reg  <= '0;
            instr_valid_reg <= 1'b0;
            misaligned_reg  <= 1'b0;
            bus_err_reg     <= 1'b0;
            tmo_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            mem_req_reg     <= mem_req_next;
            mem_addr_reg    <= mem_addr_next;
            instr_reg       <= instr_next;
            instr_addr_reg  <= instr_addr_next;
            instr_valid_reg <= instr_valid_next;
            misaligned_reg  <= misaligned_next;
            bus_err_reg     <= bus_err_next;
            tmo_cnt_reg     <= tmo_cnt_next;
        end
    end

    // Next-state and next-output logic; flush is checked first in each state.
    always_comb begin
        state_next       = state_reg;
        mem_req_next     = mem_req_reg;
        mem_addr_next    = mem_addr_reg;
        instr_next       = instr_reg;
        instr_addr_next  = instr_addr_reg;
        instr_valid_next = instr_valid_reg;
        misaligned_next  = misaligned_reg;
        bus_err_next     = bus_err_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        launch           = 1'b0;

        case (state_reg)
            IDLE: begin
                // A redirect in IDLE suppresses the fetch for this cycle.
                if (!flush && fetch_en) begin
                    launch = 1'b1;
                end
            end

            REQ: begin
                if (flush) begin
                    if (mem_ack) begin
                        // Read completes as it is cancelled: nothing left to drain.
                        state_next   = IDLE;
                        mem_req_next = 1'b0;
                    end else begin
                        // Request stays up until memory answers, then is discarded.
                        state_next   = DROP;
                        tmo_cnt_next = '0;
                    end
                end else if (mem_ack) begin
                    state_next       = HOLD;
                    mem_req_next     = 1'b0;
                    instr_next       = mem_rdata;
                    instr_valid_next = 1'b1;
                end else if (timeout_hit) begin
                    state_next       = HOLD;
                    mem_req_next     = 1'b0;
                    instr_next       = DW'(DLX_NOP);
                    bus_err_next     = 1'b1;
                    instr_valid_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end

            HOLD: begin
                if (flush) begin
                    state_next       = IDLE;
                    instr_valid_next = 1'b0;
                    misaligned_next  = 1'b0;
                    bus_err_next     = 1'b0;
                end else if (instr_ready) begin
                    instr_valid_next = 1'b0;
                    misaligned_next  = 1'b0;
                    bus_err_next     = 1'b0;
                    if (fetch_en) begin
                        launch = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            DROP: begin
                // Further flushes change nothing here; only ack or timeout leave.
                if (mem_ack || timeout_hit) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase

        // Start a fetch of the current PC (from IDLE or back-to-back from HOLD).
        if (launch) begin
            instr_addr_next = i_address;
            if (addr_misaligned) begin
                state_next       = HOLD;
                instr_next       = DW'(DLX_NOP);
                misaligned_next  = 1'b1;
                instr_valid_next = 1'b1;
            end else begin
                state_next    = REQ;
                mem_req_next  = 1'b1;
                mem_addr_next = i_address;
                tmo_cnt_next  = '0;
            end
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign instr       = instr_reg;
    assign instr_addr  = instr_addr_reg;
    assign instr_valid = instr_valid_reg;
    assign misaligned  = misaligned_reg;
    assign bus_err     = bus_err_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a vector table of single fetches,
// hand-written flush / back-to-back / reset sequences, and random fetches
// checked against a transaction-level expectation model.
module tb_ifetch_unit;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          reset;
    logic [AW-1:0] i_address;
    logic          fetch_en;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic          misaligned;
    logic          bus_err;

    int tests = 0;
    int fails = 0;

    ifetch_unit #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_address   (i_address),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .misaligned  (misaligned),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        bit          mis;
        bit          berr;
        int          lat;   // cycle (after the fetch_en edge) in which instr_valid is first seen
        bit          req;   // whether a memory request is expected at all
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          dly;   // mem_req cycles before ack (>= TIMEOUT means never)
        logic [31:0] data;
        int          rdy;   // cycles decode stalls before accepting
        exp_t        e;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome of one isolated fetch, from the externally visible rules.
    function automatic exp_t model(input logic [31:0] addr, input int dly, input logic [31:0] data);
        exp_t e;
        if (addr % 4 != 0) begin
            e.instr = 32'h0; e.mis = 1'b1; e.berr = 1'b0; e.lat = 1; e.req = 1'b0;
        end else if (dly < TIMEOUT) begin
            e.instr = data; e.mis = 1'b0; e.berr = 1'b0; e.lat = dly + 2; e.req = 1'b1;
        end else begin
            e.instr = 32'h0; e.mis = 1'b0; e.berr = 1'b1; e.lat = TIMEOUT + 1; e.req = 1'b1;
        end
        return e;
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] a, input int d, input logic [31:0] dat,
                                input int r, input logic [31:0] ei, input bit em, input bit eb,
                                input int el, input bit er);
        vec_t v;
        v.name = n; v.addr = a; v.dly = d; v.data = dat; v.rdy = r;
        v.e.instr = ei; v.e.mis = em; v.e.berr = eb; v.e.lat = el; v.e.req = er;
        return v;
    endfunction

    task automatic run_fetch(input string name, input logic [31:0] addr, input int dly,
                             input logic [31:0] data, input int rdy, input exp_t e);
        int          cyc;
        int          reqc;
        int          lat;
        bit          got;
        bit          addr_bad;
        bit          hold_bad;
        logic [31:0] held;
        @(negedge clk);
        i_address = addr;
        fetch_en  = 1'b1;
        @(posedge clk); #1;
        fetch_en  = 1'b0;
        i_address = $urandom;
        cyc = 1; reqc = 0; lat = 0; got = 1'b0; addr_bad = 1'b0;
        while (!got && cyc <= 40) begin
            mem_ack = 1'b0;
            if (instr_valid) begin
                got = 1'b1;
                lat = cyc;
            end else begin
                if (mem_req) begin
                    if (mem_addr !== addr) addr_bad = 1'b1;
                    if (reqc == dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = data;
                    end else begin
                        mem_rdata = $urandom;
                    end
                    reqc++;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        mem_ack = 1'b0;
        $display("[TB] %s addr=%08h instr=%08h mis=%0b berr=%0b lat=%0d", name, addr, instr,
                 misaligned, bus_err, lat);
        check({name, "_lat"}, 32'(lat), 32'(e.lat));
        check({name, "_instr"}, instr, e.instr);
        check({name, "_instr_addr"}, instr_addr, addr);
        check({name, "_misaligned"}, 32'(misaligned), 32'(e.mis));
        check({name, "_bus_err"}, 32'(bus_err), 32'(e.berr));
        check({name, "_req_issued"}, 32'(reqc > 0), 32'(e.req));
        check({name, "_addr_stable"}, 32'(addr_bad), 32'(0));
        held = instr; hold_bad = 1'b0;
        for (int i = 0; i < rdy; i++) begin
            @(posedge clk); #1;
            if (!instr_valid || instr !== held) hold_bad = 1'b1;
        end
        check({name, "_hold_stable"}, 32'(hold_bad), 32'(0));
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        check({name, "_accepted"}, 32'(instr_valid), 32'(0));
        check({name, "_flags_clear"}, {30'b0, misaligned, bus_err}, 32'(0));
        // A stray ack while idle must not produce anything.
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check({name, "_late_ack_ignored"}, {30'b0, mem_req, instr_valid}, 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          reqc;
        int          vcount;
        int          hs;
        logic [31:0] addr;
        int          dly;
        int          rdy;
        logic [31:0] data;
        logic [31:0] expq[$];
        logic [31:0] ex;

        vecs[0] = mk("zero_wait",   32'h100, 0,  32'h20010005, 0, 32'h20010005, 1'b0, 1'b0, 2,  1'b1);
        vecs[1] = mk("wait_bp",     32'h200, 3,  32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b0, 1'b0, 5,  1'b1);
        vecs[2] = mk("misalign2",   32'h102, 0,  32'h0,        0, 32'h0,        1'b1, 1'b0, 1,  1'b0);
        vecs[3] = mk("misalign3",   32'h303, 0,  32'h0,        2, 32'h0,        1'b1, 1'b0, 1,  1'b0);
        vecs[4] = mk("last_ack",    32'h400, 15, 32'h12345678, 0, 32'h12345678, 1'b0, 1'b0, 17, 1'b1);
        vecs[5] = mk("timeout",     32'h404, 16, 32'h0,        1, 32'h0,        1'b0, 1'b1, 17, 1'b1);
        vecs[6] = mk("timeout_far", 32'h408, 99, 32'h0,        3, 32'h0,        1'b0, 1'b1, 17, 1'b1);

        reset = 1'b1; i_address = '0; fetch_en = 1'b0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {25'b0, mem_req, instr_valid, misaligned, bus_err, 3'b0}, 32'(0));
        check("reset_instr", instr, 32'h0);
        check("reset_instr_addr", instr_addr, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_fetch(vecs[i].name, vecs[i].addr, vecs[i].dly, vecs[i].data, vecs[i].rdy, vecs[i].e);
        end

        // Flush in the second REQ cycle; ack two cycles later is drained and dropped.
        @(negedge clk); i_address = 32'h500; fetch_en = 1'b1;
        @(posedge clk); #1; fetch_en = 1'b0;
        reqc = 0; vcount = 0;
        for (int c = 1; c <= 8; c++) begin
            flush     = (c == 2);
            mem_ack   = (c == 4);
            mem_rdata = 32'hDEADBEEF;
            if (mem_req) reqc++;
            if (instr_valid) vcount++;
            if (c == 5) check("flush_req_released", 32'(mem_req), 32'(0));
            @(posedge clk); #1;
        end
        flush = 1'b0; mem_ack = 1'b0;
        $display("[TB] flush_req req_cycles=%0d valid_cycles=%0d", reqc, vcount);
        check("flush_req_cycles", 32'(reqc), 32'(4));
        check("flush_no_valid", 32'(vcount), 32'(0));

        // Flush while holding an instruction: valid drops the next cycle.
        @(negedge clk); i_address = 32'h600; fetch_en = 1'b1;
        @(posedge clk); #1; fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11112222;
        @(posedge clk); #1; mem_ack = 1'b0;
        check("hflush_valid_before", 32'(instr_valid), 32'(1));
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        $display("[TB] flush_hold valid_after=%0b", instr_valid);
        check("hflush_valid_dropped", 32'(instr_valid), 32'(0));
        @(posedge clk); #1;
        check("hflush_stays_idle", {30'b0, mem_req, instr_valid}, 32'(0));

        // Flush in the same cycle as the ack: data discarded, straight to IDLE.
        @(negedge clk); i_address = 32'h680; fetch_en = 1'b1;
        @(posedge clk); #1; fetch_en = 1'b0; mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'h33334444;
        @(posedge clk); #1; mem_ack = 1'b0; flush = 1'b0;
        check("aflush_req_cleared", 32'(mem_req), 32'(0));
        vcount = 0;
        for (int c = 0; c < 3; c++) begin
            if (instr_valid) vcount++;
            @(posedge clk); #1;
        end
        $display("[TB] flush_ack valid_cycles=%0d", vcount);
        check("aflush_no_valid", 32'(vcount), 32'(0));

        // Flush in IDLE overrides a simultaneous fetch request.
        @(negedge clk); i_address = 32'h6C0; fetch_en = 1'b1; flush = 1'b1;
        @(posedge clk); #1; fetch_en = 1'b0; flush = 1'b0;
        $display("[TB] flush_idle req=%0b valid=%0b", mem_req, instr_valid);
        check("iflush_no_fetch", {30'b0, mem_req, instr_valid}, 32'(0));

        // Back-to-back zero-wait fetches with decode always ready: one per 2 cycles.
        @(negedge clk); i_address = 32'h800; fetch_en = 1'b1; instr_ready = 1'b1;
        @(posedge clk); #1;
        hs = 0;
        for (int c = 1; c <= 8; c++) begin
            fetch_en = (c < 8);
            mem_ack  = 1'b0;
            if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hB000_0000 + 32'(c);
                expq.push_back(mem_rdata);
            end
            if (instr_valid) begin
                hs++;
                ex = (expq.size() > 0) ? expq.pop_front() : 32'hFFFF_FFFF;
                check($sformatf("b2b_instr%0d", hs), instr, ex);
            end
            @(posedge clk); #1;
        end
        fetch_en = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0;
        $display("[TB] back_to_back handshakes=%0d", hs);
        check("b2b_handshakes", 32'(hs), 32'(4));
        check("b2b_idle_after", {30'b0, mem_req, instr_valid}, 32'(0));

        // Asynchronous reset between clock edges while a request is outstanding.
        @(negedge clk); i_address = 32'h700; fetch_en = 1'b1;
        @(posedge clk); #1; fetch_en = 1'b0;
        @(posedge clk); #1;
        check("areset_req_before", 32'(mem_req), 32'(1));
        #2 reset = 1'b1;
        #1;
        $display("[TB] async_reset req=%0b valid=%0b", mem_req, instr_valid);
        check("areset_immediate", {30'b0, mem_req, instr_valid}, 32'(0));
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0;
        run_fetch("after_reset", 32'h104, 1, 32'h0BADCAFE, 1, model(32'h104, 1, 32'h0BADCAFE));

        // Random isolated fetches against the expectation model.
        for (int t = 0; t < 40; t++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            dly  = $urandom_range(0, TIMEOUT + 3);
            data = $urandom;
            rdy  = $urandom_range(0, 3);
            run_fetch($sformatf("rand%0d", t), addr, dly, data, rdy, model(addr, dly, data));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch reader at the far end of the program counter's `i_address` output. It samples the current fetch address and issues a single-outstanding read over a req/ack instruction-memory handshake. It captures the returned word into an instruction register and presents it to decode over a valid/ready handshake. It also handles PC redirects (flush), misaligned addresses and memory timeouts.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, instruction width
- `TIMEOUT`, 16, maximum cycles in REQ without `mem_ack` before a bus error (≥2)

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `i_address`  in  AW  current PC, from the program counter
- `fetch_en`  in  1  pipeline requests a fetch of `i_address`
- `flush`  in  1  PC redirect; discard any fetch in progress
- `mem_req`  out  1  read request to instruction memory
- `mem_addr`  out  AW  read address, stable while `mem_req`=1
- `mem_ack`  in  1  memory completes the read; `mem_rdata` valid the same cycle
- `mem_rdata`  in  DW  read data
- `instr`  out  DW  fetched instruction
- `instr_addr`  out  AW  address `instr` was fetched from
- `instr_valid`  out  1  `instr` is valid
- `instr_ready`  in  1  decode accepts `instr`
- `misaligned`  out  1  qualifies `instr_valid`: `instr_addr[1:0]`≠0
- `bus_err`  out  1  qualifies `instr_valid`: memory timed out

## Operation
- Reset values: state IDLE; `mem_req`=0, `mem_addr`=0, `instr`=0, `instr_addr`=0, `instr_valid`=0, `misaligned`=0, `bus_err`=0, timeout counter=0.
- All outputs are registered.
- FSM states are IDLE, REQ, HOLD and DROP. `flush` has priority over every other transition.
- IDLE:
  - `fetch_en`=1 and aligned → REQ. Latch `mem_addr`=`instr_addr`=`i_address` and set `mem_req`=1.
  - `fetch_en`=1 and `i_address[1:0]`≠0 → HOLD with `instr`=NOP (32'h0), `misaligned`=1. No memory request is issued.
- REQ:
  - `mem_req` is held with `mem_addr` stable until `mem_ack`.
  - `mem_ack`=1 → HOLD. Capture `instr`=`mem_rdata`, clear `mem_req`.
  - Counter reaches `TIMEOUT`-1 without ack → HOLD with `instr`=NOP, `bus_err`=1, `mem_req` cleared.
- HOLD:
  - `instr_valid`=1, and `instr`, `instr_addr` and the flags are held stable.
  - `instr_ready`=1 with `fetch_en`=1 → start the next fetch directly, as in IDLE (back-to-back).
  - `instr_ready`=1 without `fetch_en` → IDLE.
  - Flags clear when the instruction is accepted.
- DROP (outstanding request discarded):
  - Keep `mem_req` until `mem_ack`, then → IDLE.
  - `instr_valid` stays 0 and the data is discarded.
  - Timeout also exits to IDLE.
- `flush` behaviour by state:
  - REQ with no ack that cycle → DROP.
  - REQ with `mem_ack` the same cycle → IDLE, data discarded.
  - HOLD → IDLE; `instr_valid` drops the next cycle.
  - IDLE → stay IDLE, even if `fetch_en`=1.
- A `mem_ack` arriving in IDLE or HOLD (late ack after a timeout) is ignored.
- The timeout counter is $clog2(TIMEOUT) bits. It clears on entry to REQ or DROP and saturates; it never wraps.
- Reset mid-transaction returns to IDLE immediately. `mem_req` drops asynchronously.

## Timing
- `fetch_en` sampled at edge 0 → `mem_req` high in cycle 1.
- `mem_ack` sampled at edge k → `instr_valid` high from cycle k+1.
- Zero-wait memory (ack in the first REQ cycle) gives 2-cycle latency, `fetch_en` to `instr_valid`.
- Back-to-back sustained throughput is one instruction every 2 cycles.
- Misaligned fault: `instr_valid` in cycle 1.
- Timeout: `instr_valid` is asserted `TIMEOUT` cycles after `mem_req` first rises.
- `flush` at edge n: no `instr_valid` in cycle n+1 or later for the discarded fetch.

## Structure
- Shared package `dlx_pkg` holds:
  - the fetch state enum (IDLE, REQ, HOLD, DROP)
  - `DLX_NOP` = 32'h0
  - `INSTR_ALIGN` = 2 (low address bits checked)
- Single module. The timeout counter is small enough to stay inline; no sub-module.

## Test plan
- Zero-wait fetch: `i_address`=0x100, `fetch_en` at edge 0, `mem_ack` in cycle 1 with `mem_rdata`=0x20010005 → `instr`=0x20010005, `instr_addr`=0x100, `instr_valid` in cycle 2.
- Wait states with backpressure: ack after 3 cycles, `instr_ready` held low 4 cycles → `mem_addr` stable throughout REQ, `instr` stable through HOLD, exactly one handshake.
- Flush: `flush` in the second REQ cycle, ack 2 cycles later with 0xDEADBEEF → no `instr_valid`, `mem_req` held until ack, then IDLE.
- Misaligned: `i_address`=0x102 → no `mem_req`, `instr_valid` in cycle 1 with `instr`=0, `misaligned`=1.
- Timeout: `TIMEOUT`=16, no ack → `bus_err`=1 and `instr_valid` 16 cycles after `mem_req` rises; a late ack afterwards is ignored.
- Async reset asserted mid-REQ (between clock edges) → `mem_req` and `instr_valid` go 0 immediately; the FSM restarts cleanly after release.
